// File: rtl/mult4_pkg.sv
// rtl/mult4_pkg.sv - shared state encoding and chunk sizing for the byte-serial multiplier
package mult4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult4_state_t;

  localparam int CHUNK = 8;

  function automatic int n_chunks(input int width);
    return width / CHUNK;
  endfunction

  // A single-chunk build still needs a 1-bit counter to hold the BUSY step.
  function automatic int cnt_width(input int width);
    return (n_chunks(width) > 1) ? $clog2(n_chunks(width)) : 1;
  endfunction

endpackage

// File: rtl/mult4_unit_mult_chunk.sv
// rtl/mult4_unit_mult_chunk.sv - WIDTH x 8 partial product shifted into place by chunk index
module mult_chunk
  import mult4_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] pp
);

  int               shamt;
  logic [CHUNK-1:0] b_byte;
  logic [WIDTH-1:0] prod;

  always_comb begin
    shamt  = CHUNK * int'(cnt);
    b_byte = CHUNK'(b >> shamt);
    prod   = a * WIDTH'(b_byte);
    pp     = prod << shamt;
  end

endmodule

// File: rtl/mult4_unit.sv
// rtl/mult4_unit.sv - multi-cycle unsigned multiplier for the EX stage, one byte of b per cycle
module mult4_unit
  import mult4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int N_CHUNKS = n_chunks(WIDTH);
  localparam int CNT_W    = cnt_width(WIDTH);

  mult4_state_t     state, state_next;
  logic             accept;
  logic             last_chunk;
  logic [WIDTH-1:0] a_q, b_q, acc, pp;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [CNT_W-1:0] cnt, mul_cnt;
  logic [4:0]       rd_q;

  assign last_chunk = (N_CHUNKS == 1) || (cnt == CNT_W'(N_CHUNKS - 1));

  // The accepting edge computes chunk 0 straight from the forwarded operands.
  assign mul_a   = (state == BUSY) ? a_q : operand_a;
  assign mul_b   = (state == BUSY) ? b_q : operand_b;
  assign mul_cnt = (state == BUSY) ? cnt : '0;

  mult_chunk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chunk (
    .a   (mul_a),
    .b   (mul_b),
    .cnt (mul_cnt),
    .pp  (pp)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stall      = 1'b0;
    case (state)
      BUSY: begin
        stall = 1'b1;
        if (flush)           state_next = IDLE;
        else if (last_chunk) state_next = DONE;
      end
      IDLE, DONE: begin
        accept     = start & ~flush;
        stall      = accept;
        state_next = accept ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
    stall = stall & arst_n;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= (state_next == DONE);
      if (accept) begin
        a_q  <= operand_a;
        b_q  <= operand_b;
        rd_q <= rd_in;
        acc  <= pp;
        cnt  <= CNT_W'(1);
      end else if (state == BUSY && !flush) begin
        acc <= acc + pp;
        cnt <= cnt + CNT_W'(1);
        // Outputs only move on completion so a squashed multiply leaves them intact.
        if (last_chunk) begin
          result <= acc + pp;
          rd_out <= rd_q;
        end
      end
    end
  end

endmodule
